mem_be_pipe: RTL and testbench
==============================

# mem_be_pipe

Parametrised single-port synchronous memory with per-byte write strobes, configurable read latency and out-of-range address detection. It replaces the fixed-latency byte-wide memory as the general storage block behind the valid/ready request interface. It serves any bus master in the design that issues one request at a time.

## Interface
- WIDTH, 32, data word width in bits; multiple of 8, minimum 8
- SIZE, 8192, total capacity in bits; multiple of WIDTH
- DEPTH, SIZE/WIDTH, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- RD_LATENCY, 1, read latency in cycles; legal range 1..4
- clk_i  in  1  clock; all logic is rising-edge triggered
- rst_i  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk_i from the system
- valid_i  in  1  request valid
- ready_o  out  1  block can accept a request this cycle
- wr_rd_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  word address
- wdata_i  in  WIDTH  write data
- wstrb_i  in  WIDTH/8  byte write enables; bit k covers wdata_i[8k+7:8k]
- rdata_o  out  WIDTH  read data; valid only while rvalid_o=1
- rvalid_o  out  1  one-cycle read-completion pulse
- err_o  out  1  one-cycle pulse: the completed request had addr_i >= DEPTH

## Operation
- Handshake: a request is accepted on a rising edge where valid_i=1 and ready_o=1. Inputs are sampled only at that edge.
- One outstanding request. There is no read queueing.
- Control FSM:
  - IDLE: ready_o=1.
  - Read accept with RD_LATENCY=1: stay in IDLE.
  - Read accept with RD_LATENCY>1: go to RD_WAIT.
  - RD_WAIT: down-counter loaded with RD_LATENCY-1 at accept. ready_o=0 until the cycle in which rvalid_o=1. Return to IDLE on the edge that launches rvalid_o.
- Write behaviour:
  - Completes at the accept edge.
  - Only bytes with wstrb_i[k]=1 are updated.
  - wstrb_i=0 is a legal no-op write.
  - Writes produce no rvalid_o.
- Read behaviour:
  - rdata_o carries the word stored at the accept edge.
  - All bytes are returned regardless of wstrb_i.
- Out-of-range address (addr_i >= DEPTH):
  - Write: the memory array is left unchanged. err_o=1 in the cycle after accept.
  - Read: rdata_o=0. err_o=1 in the same cycle as rvalid_o=1.
- Memory array:
  - Not cleared by reset. Contents persist across rst_i.
  - Contents are undefined (X) after power-up until first written.
- Reset (rst_i=0), asynchronous and immediate:
  - FSM goes to IDLE.
  - Pipeline and counter cleared.
  - ready_o=0 while rst_i=0, and 1 in the first cycle after release.
  - rvalid_o=0, err_o=0, rdata_o=0.
  - A read in flight is dropped: no rvalid_o after reset.
  - A write is discarded unless its accept edge preceded the reset.

## Timing
- Read accepted at edge N: rvalid_o=1 and rdata_o valid in the cycle after edge N+RD_LATENCY-1. That is one cycle after accept for RD_LATENCY=1.
- Read throughput:
  - RD_LATENCY=1: back-to-back reads, one per cycle.
  - Otherwise: one read per RD_LATENCY cycles, because ready_o rises with rvalid_o.
- Write throughput: one per cycle. ready_o is never lowered by writes.
- Read-after-write to the same address: a read accepted on the edge after the write returns the new data, including the merged strobed bytes.
- rdata_o between completions: drives 0 whenever rvalid_o=0 (reset value 0).
- err_o: never asserted for in-range requests.
- Requests: valid_i may drop without being accepted; no penalty. There are no X-propagation requirements on inputs while valid_i=0.

## Test plan
- Defaults (WIDTH=32, SIZE=8192, DEPTH=256, RD_LATENCY=1): write 0xDEADBEEF to addr 0x15 with wstrb 0xF, then read 0x15. Required: rvalid_o one cycle after read accept, rdata_o=0xDEADBEEF, err_o=0.
- Byte strobes:
  - Write 0x11223344 to addr 7 with wstrb 0xF.
  - Write 0xAABBCCDD with wstrb 0x5.
  - Read addr 7. Required: rdata_o=0x11BB33DD.
- RD_LATENCY=3, all 256 locations:
  - Write $random to each location; read all back.
  - Required: every rvalid_o arrives exactly 3 cycles after accept and matches the scoreboard.
  - Required: ready_o=0 for exactly 2 cycles after each read accept.
- SIZE=6144 (DEPTH=192, ADDR_WIDTH=8):
  - Write 0x5 to addr 200. Required: err_o pulse one cycle later.
  - Read addr 200. Required: rdata_o=0, err_o=1 with rvalid_o.
  - Read addr 191 (previously written 0x9). Required: 0x9, err_o=0.
- Reset mid-read, RD_LATENCY=4:
  - Drive rst_i=0 one cycle after read accept; release after 2 cycles.
  - Required: no rvalid_o at any point, ready_o=1 on the first cycle after release.
  - Required: a prior write to addr 3 (0xCAFE0001) still reads back correctly.
- Back-to-back, RD_LATENCY=1: write addr 10 = 0x01020304 then read addr 10 on the next edge. Required: rdata_o=0x01020304 one cycle later, no idle cycles inserted.

Source files
------------

// File: rtl/mem_be_pipe.sv
// Single-port word memory with per-byte write strobes, RD_LATENCY-cycle reads
// and out-of-range address flagging behind a one-outstanding valid/ready port.
module mem_be_pipe #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SIZE       = 8192,
   parameter int unsigned DEPTH      = SIZE / WIDTH,
   parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic                    wr_rd_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic [WIDTH/8-1:0]      wstrb_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic                    rvalid_o,
   output logic                    err_o
);

   localparam int unsigned NBYTES = WIDTH / 8;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_RD_WAIT = 1'b1
   } state_t;

   logic [WIDTH-1:0]      mem [DEPTH];

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [WIDTH-1:0]      hold_data;
   logic                  hold_err;

   logic                  accept;
   logic                  in_range;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [WIDTH-1:0]      rd_word;
   logic [WIDTH-1:0]      bmask;

   assign accept   = valid_i & ready_o;
   assign in_range = (32'(addr_i) < DEPTH);
   assign wr_en    = accept & wr_rd_i & in_range;
   assign rd_idx   = in_range ? addr_i : '0;
   assign rd_word  = in_range ? mem[rd_idx] : '0;

   // Expand byte strobes into a bit mask for the read-modify-write merge.
   for (genvar k = 0; k < NBYTES; k++) begin : g_mask
      assign bmask[8*k +: 8] = {8{wstrb_i[k]}};
   end

   // Array is deliberately not reset so contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[addr_i] <= (mem[addr_i] & ~bmask) | (wdata_i & bmask);
      end
   end

   // Control FSM; read data is captured at accept and released after the countdown.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hold_data <= '0;
         hold_err  <= 1'b0;
         ready_o   <= 1'b0;
         rvalid_o  <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= '0;
      end else begin
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         case (state)
            S_IDLE: begin
               ready_o <= 1'b1;
               if (accept) begin
                  if (wr_rd_i) begin
                     err_o <= ~in_range;
                  end else if (RD_LATENCY == 1) begin
                     rvalid_o <= 1'b1;
                     rdata_o  <= rd_word;
                     err_o    <= ~in_range;
                  end else begin
                     state     <= S_RD_WAIT;
                     cnt       <= CNT_W'(RD_LATENCY - 1);
                     hold_data <= rd_word;
                     hold_err  <= ~in_range;
                     ready_o   <= 1'b0;
                  end
               end
            end
            S_RD_WAIT: begin
               ready_o <= 1'b0;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b1;
                  rvalid_o <= 1'b1;
                  rdata_o  <= hold_data;
                  err_o    <= hold_err;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_be_pipe.sv
// Bench for mem_be_pipe: three instances (latency 1, latency 3, 192-word latency 4)
// driven with directed and random requests against a word-array reference model.
module tb_mem_be_pipe;

   logic        clk;
   logic        rst    [3];
   logic        valid  [3];
   logic        ready  [3];
   logic        wr_rd  [3];
   logic [7:0]  addr   [3];
   logic [31:0] wdata  [3];
   logic [3:0]  wstrb  [3];
   logic [31:0] rdata  [3];
   logic        rvalid [3];
   logic        err    [3];

   int unsigned lat   [3] = '{1, 3, 4};
   int unsigned depth [3] = '{256, 256, 192};

   logic [31:0] mdl [3][256];
   bit          wrn [3][256];

   int n_chk;
   int n_pass;
   int last_wait;
   bit watch2;
   int rv_seen2;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_be_pipe #(
         .WIDTH      (32),
         .SIZE       ((g == 2) ? 6144 : 8192),
         .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk_i    (clk),
         .rst_i    (rst[g]),
         .valid_i  (valid[g]),
         .ready_o  (ready[g]),
         .wr_rd_i  (wr_rd[g]),
         .addr_i   (addr[g]),
         .wdata_i  (wdata[g]),
         .wstrb_i  (wstrb[g]),
         .rdata_o  (rdata[g]),
         .rvalid_o (rvalid[g]),
         .err_o    (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch2 && rvalid[2]) rv_seen2 <= rv_seen2 + 1;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic wait_ready(input int i, output bit ok, output int w);
      ok = 1'b0;
      w  = 0;
      for (int c = 0; c < 32; c++) begin
         if (ready[i]) begin
            ok = 1'b1;
            break;
         end
         w++;
         @(negedge clk);
      end
      if (!ok) chk("ready_timeout", 32'(ready[i]), 32'd1);
   endtask

   task automatic do_write(input int i, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bit          ok;
      int          w;
      bit          oor;
      logic [31:0] m;
      oor = (32'(a) >= depth[i]);
      wait_ready(i, ok, w);
      if (!ok) return;
      valid[i] = 1'b1;
      wr_rd[i] = 1'b1;
      addr[i]  = a;
      wdata[i] = d;
      wstrb[i] = s;
      @(posedge clk);
      if (!oor) begin
         m = 32'h0;
         for (int k = 0; k < 4; k++)
            if (((s >> k) & 4'd1) != 4'd0) m = m | (32'hFF << (8 * k));
         mdl[i][a] = (mdl[i][a] & ~m) | (d & m);
         if (s == 4'hF) wrn[i][a] = 1'b1;
      end
      @(negedge clk);
      valid[i] = 1'b0;
      chk($sformatf("wr_err[%0d]@%0h", i, a), 32'(err[i]), 32'(oor));
      chk("wr_rvalid", 32'(rvalid[i]), 32'd0);
      chk("wr_ready", 32'(ready[i]), 32'd1);
      chk("wr_rdata_idle", rdata[i], 32'd0);
   endtask

   task automatic do_read(input int i, input logic [7:0] a);
      bit          ok;
      int          w;
      bit          oor;
      logic [31:0] exp;
      oor = (32'(a) >= depth[i]);
      exp = oor ? 32'h0 : mdl[i][a];
      wait_ready(i, ok, w);
      last_wait = w;
      if (!ok) return;
      valid[i] = 1'b1;
      wr_rd[i] = 1'b0;
      addr[i]  = a;
      wdata[i] = $urandom;
      wstrb[i] = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      valid[i] = 1'b0;
      for (int c = 1; c < int'(lat[i]); c++) begin
         chk("rd_wait_rvalid", 32'(rvalid[i]), 32'd0);
         chk("rd_wait_ready", 32'(ready[i]), 32'd0);
         chk("rd_wait_rdata", rdata[i], 32'd0);
         @(negedge clk);
      end
      chk($sformatf("rd_rvalid[%0d]@%0h", i, a), 32'(rvalid[i]), 32'd1);
      chk($sformatf("rd_data[%0d]@%0h", i, a), rdata[i], exp);
      chk($sformatf("rd_err[%0d]@%0h", i, a), 32'(err[i]), 32'(oor));
      chk("rd_ready", 32'(ready[i]), 32'd1);
   endtask

   task automatic rand_ops(input int i, input int n, input int amax);
      logic [7:0] a;
      bit         oor;
      for (int t = 0; t < n; t++) begin
         a   = 8'($urandom_range(0, amax));
         oor = (32'(a) >= depth[i]);
         if (!oor && !wrn[i][a]) do_write(i, a, $urandom, 4'hF);
         else if ($urandom_range(0, 1) == 0) do_write(i, a, $urandom, 4'($urandom));
         else do_read(i, a);
      end
   endtask

   initial begin
      bit ok;
      int w;
      n_chk  = 0;
      n_pass = 0;
      watch2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst[i]   = 1'b0;
         valid[i] = 1'b0;
         wr_rd[i] = 1'b0;
         addr[i]  = 8'h0;
         wdata[i] = 32'h0;
         wstrb[i] = 4'h0;
      end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_ready", 32'(ready[i]), 32'd0);
         chk("reset_rvalid", 32'(rvalid[i]), 32'd0);
         chk("reset_err", 32'(err[i]), 32'd0);
         chk("reset_rdata", rdata[i], 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) rst[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("post_reset_ready", 32'(ready[i]), 32'd1);

      // Latency 1: basic, byte strobes, back-to-back, random mix
      do_write(0, 8'h15, 32'hDEADBEEF, 4'hF);
      do_read(0, 8'h15);
      do_write(0, 8'h07, 32'h11223344, 4'hF);
      do_write(0, 8'h07, 32'hAABBCCDD, 4'h5);
      do_read(0, 8'h07);
      do_write(0, 8'h07, 32'h55667788, 4'h0);
      do_read(0, 8'h07);
      do_write(0, 8'h0A, 32'h01020304, 4'hF);
      do_read(0, 8'h0A);
      chk("b2b_stall", 32'(last_wait), 32'd0);
      do_read(0, 8'h15);
      chk("b2b_read_stall", 32'(last_wait), 32'd0);
      rand_ops(0, 200, 31);

      // Latency 3: fill every location, read all back
      for (int a = 0; a < 256; a++) do_write(1, 8'(a), $urandom, 4'hF);
      for (int a = 0; a < 256; a++) do_read(1, 8'(a));

      // 192-word, latency 4: out-of-range handling
      do_write(2, 8'd191, 32'h9, 4'hF);
      do_write(2, 8'd200, 32'h5, 4'hF);
      do_read(2, 8'd200);
      do_read(2, 8'd191);
      do_read(2, 8'd255);
      do_write(2, 8'd192, 32'hFFFF_FFFF, 4'hF);
      do_read(2, 8'd191);

      // Reset while a read is in flight
      do_write(2, 8'd3, 32'hCAFE0001, 4'hF);
      wait_ready(2, ok, w);
      valid[2]  = 1'b1;
      wr_rd[2]  = 1'b0;
      addr[2]   = 8'd3;
      watch2    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid[2] = 1'b0;
      @(posedge clk);
      #1 rst[2] = 1'b0;
      #1;
      chk("inrst_ready", 32'(ready[2]), 32'd0);
      chk("inrst_rvalid", 32'(rvalid[2]), 32'd0);
      chk("inrst_rdata", rdata[2], 32'd0);
      chk("inrst_err", 32'(err[2]), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst[2] = 1'b1;
      @(posedge clk);
      #1;
      chk("release_ready", 32'(ready[2]), 32'd1);
      repeat (6) @(negedge clk);
      watch2 = 1'b0;
      chk("rst_no_rvalid", 32'(rv_seen2), 32'd0);
      do_read(2, 8'd3);
      do_read(2, 8'd191);

      rand_ops(2, 150, 255);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
